seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
- Time-multiplexes a 4-digit common-anode 7-segment display through one shared BCD-to-7-segment decoder.
- Drives the decoder's 4-bit code input and the active-low digit anodes.
- Inserts a blanking gap between digits to prevent ghosting and supports leading-zero suppression.
- Takes new display values over a load/ack handshake and commits them only at frame boundaries, so a frame never shows mixed old and new digits.

Parameters:
DIGIT_TICKS, 50000, clock cycles each digit is lit (>=1)
BLANK_TICKS, 500, clock cycles all anodes are off after each digit (0 = no gap)
CNT_W, 17, tick counter width; must hold max(DIGIT_TICKS, BLANK_TICKS)-1

Ports:
clk_i  in  1  system clock
reset_i  in  1  synchronous, active-high reset
enable_i  in  1  1 = scanning; 0 = display dark, sequencer held in START
lzb_i  in  1  1 = leading-zero blanking enabled
load_i  in  1  one-cycle strobe: data_i is a new display value
data_i  in  16  four 4-bit codes; [3:0] = digit 0 (rightmost), [15:12] = digit 3
load_ack_o  out  1  one-cycle pulse: a loaded value was committed to display
frame_o  out  1  one-cycle pulse on every frame-boundary cycle
bcd_o  out  4  code to the decoder; 4'hF = blank (decoder outputs all segments off)
an_o  out  4  active-low anode enables; bit d = digit d
digit_o  out  2  index of the digit currently selected

Behaviour:
- Single clock; reset is synchronous and active-high. All state is updated on the rising edge of clk_i.
- Outputs are a Moore function of the registered state; there is no combinational path from any input to any output.
- Reset values: state = START, tick counter = 0, digit = 0, display register = 16'hFFFF, pending register = 16'hFFFF, pending valid = 0, load_ack_o = 0, frame_o = 0, an_o = 4'b1111, bcd_o = 4'hF, digit_o = 0.
- States:
  - START: lasts 1 cycle. an_o = 1111, bcd_o = F. Next state is SHOW, digit 0, counter 0.
  - SHOW: an_o = ~(1 << digit), bcd_o = effective code of that digit. Lasts DIGIT_TICKS cycles (counter 0..DIGIT_TICKS-1), then goes to BLANK with counter 0. If BLANK_TICKS = 0, it goes straight to SHOW of the next digit.
  - BLANK: an_o = 1111, bcd_o = F, digit_o holds the last lit digit. Lasts BLANK_TICKS cycles, then goes to SHOW of digit+1 mod 4.
- Digit order is 0, 1, 2, 3, 0, ...
- Frame period = 4*(DIGIT_TICKS+BLANK_TICKS) cycles.
- Frame-boundary cycle, defined as either:
  - the START cycle, or
  - the final cycle of digit 3's BLANK (or of digit 3's SHOW when BLANK_TICKS = 0).
- On a boundary cycle, frame_o = 1 during that cycle.
- Commit rule on a boundary cycle:
  - If load_i = 1, data_i is committed.
  - Otherwise, if pending valid = 1, the pending register is committed.
  - The committed value appears from the next cycle (digit 0 SHOW). pending valid clears.
  - load_ack_o = 1 in the cycle after the commit.
- load_i on a non-boundary cycle writes the pending register and sets pending valid. A second load before the boundary overwrites it (newest wins); only one ack is produced.
- Effective code, when lzb_i = 1:
  - Digit d in 3..1 shows F if its code and every higher digit's code are 0.
  - Digit 0 is never suppressed.
  - Suppression is evaluated continuously on the display register.
- enable_i = 0:
  - The next state is START with counter 0 and digit 0, held there for as long as enable_i is low. Outputs are dark.
  - Loads are still accepted into the pending register.
  - Because START is a boundary cycle, a pending or same-cycle load commits while disabled, and frame_o pulses every cycle while enable_i = 0.
- reset_i asserted mid-frame: the next cycle is in the reset state. Pending data and any due ack are discarded.

Test Plan:
(Parameters for all scenarios: DIGIT_TICKS = 4, BLANK_TICKS = 2.)
- Scan timing: release reset, then load 16'h1234 on the START cycle.
  - load_ack_o pulses 1 cycle later.
  - an_o sequence: 1110 x4 cycles (bcd 4), 1111 x2, 1101 x4 (bcd 3), 1111 x2, 1011 x4 (bcd 2), 1111 x2, 0111 x4 (bcd 1), 1111 x2.
  - frame_o pulses every 24 cycles.
- Anti-tearing: load 16'h5678 while digit 1 is lit.
  - The rest of the frame still shows 1234.
  - load_ack_o pulses the cycle after the boundary; the next frame shows 8, 7, 6, 5.
- Overwrite: load 16'h1111 then 16'h2222 within one frame.
  - Exactly one ack; the next frame shows 2222.
- Leading-zero blanking: display 16'h0070 with lzb_i = 1.
  - bcd_o for digits 0..3 = 0, 7, F, F.
  - With lzb_i = 0: 0, 7, 0, 0.
  - Display 16'h0000 with lzb_i = 1: 0, F, F, F.
- Boundary collision: assert load_i with 16'hABCD exactly on the boundary cycle while the pending register holds 16'h9999.
  - ABCD is committed; 9999 is dropped; one ack.
- Enable/reset: drop enable_i mid-digit 2.
  - an_o = 1111 from the next cycle onward.
  - Re-enable: START, then digit 0 lit.
  - Assert reset_i during SHOW: all outputs return to reset values next cycle; the display shows blanks (FFFF) afterwards.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - 4-digit multiplexed 7-segment scan controller with frame-synchronous value commit
module seg_scan_ctrl #(
    parameter int DIGIT_TICKS = 50000,
    parameter int BLANK_TICKS = 500,
    parameter int CNT_W       = 17
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        enable_i,
    input  logic        lzb_i,
    input  logic        load_i,
    input  logic [15:0] data_i,
    output logic        load_ack_o,
    output logic        frame_o,
    output logic [3:0]  bcd_o,
    output logic [3:0]  an_o,
    output logic [1:0]  digit_o
);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_SHOW  = 2'd1,
        ST_BLANK = 2'd2
    } state_t;

    // A zero-length gap skips BLANK entirely; the last-tick constant is then unused.
    localparam bit             HAS_BLANK  = (BLANK_TICKS > 0);
    localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_TICKS - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(HAS_BLANK ? BLANK_TICKS - 1 : 0);
    localparam logic [3:0]     CODE_BLANK = 4'hF;

    // Sequencer state
    state_t           state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [1:0]       digit_q, digit_n;

    // Display value and the value waiting for the next frame boundary
    logic [15:0]      disp_q, disp_n;
    logic [15:0]      pend_q, pend_n;
    logic             pend_vld_q, pend_vld_n;

    // Registered outputs, computed from the next state so that outputs never
    // depend combinationally on inputs.
    logic             ack_q, ack_n;
    logic             frame_q, frame_n;
    logic [3:0]       an_q, an_n;
    logic [3:0]       bcd_q, bcd_n;

    logic             boundary;

    // A frame boundary is the START cycle or the last cycle of digit 3's
    // slot (its BLANK, or its SHOW when there is no gap).
    function automatic logic is_boundary(input state_t st, input logic [1:0] dg,
                                         input logic [CNT_W-1:0] cn);
        logic last_slot;
        if (HAS_BLANK) begin
            last_slot = (st == ST_BLANK) && (dg == 2'd3) && (cn == BLANK_LAST);
        end else begin
            last_slot = (st == ST_SHOW) && (dg == 2'd3) && (cn == DIGIT_LAST);
        end
        return (st == ST_START) || last_slot;
    endfunction

    // Code sent to the decoder for digit dg, with leading zeros replaced by
    // blank when blanking is on. Digit 0 always shows its code.
    function automatic logic [3:0] eff_code(input logic [15:0] v, input logic [1:0] dg,
                                            input logic lzb);
        logic [3:0] lead_zero;
        logic [3:0] code;
        lead_zero[3] = (v[15:12] == 4'h0);
        lead_zero[2] = lead_zero[3] && (v[11:8] == 4'h0);
        lead_zero[1] = lead_zero[2] && (v[7:4] == 4'h0);
        lead_zero[0] = 1'b0;
        case (dg)
            2'd0:    code = v[3:0];
            2'd1:    code = v[7:4];
            2'd2:    code = v[11:8];
            default: code = v[15:12];
        endcase
        if (lzb && lead_zero[dg]) begin
            code = CODE_BLANK;
        end
        return code;
    endfunction

    assign boundary = is_boundary(state_q, digit_q, cnt_q);

    // Next-state, commit and output computation
    always_comb begin
        state_n    = state_q;
        cnt_n      = cnt_q;
        digit_n    = digit_q;
        disp_n     = disp_q;
        pend_n     = pend_q;
        pend_vld_n = pend_vld_q;
        ack_n      = 1'b0;
        frame_n    = 1'b0;
        an_n       = 4'b1111;
        bcd_n      = CODE_BLANK;

        // Scan sequencing
        if (!enable_i) begin
            state_n = ST_START;
            cnt_n   = '0;
            digit_n = 2'd0;
        end else begin
            case (state_q)
                ST_START: begin
                    state_n = ST_SHOW;
                    cnt_n   = '0;
                    digit_n = 2'd0;
                end
                ST_SHOW: begin
                    if (cnt_q == DIGIT_LAST) begin
                        cnt_n = '0;
                        if (HAS_BLANK) begin
                            state_n = ST_BLANK;
                        end else begin
                            state_n = ST_SHOW;
                            digit_n = digit_q + 2'd1;
                        end
                    end else begin
                        cnt_n = cnt_q + 1'b1;
                    end
                end
                ST_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_n = ST_SHOW;
                        cnt_n   = '0;
                        digit_n = digit_q + 2'd1;
                    end else begin
                        cnt_n = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_n = ST_START;
                    cnt_n   = '0;
                    digit_n = 2'd0;
                end
            endcase
        end

        // Commit only on a boundary so a frame never mixes old and new digits;
        // a same-cycle load wins over an older pending value.
        if (boundary) begin
            if (load_i) begin
                disp_n = data_i;
            end else if (pend_vld_q) begin
                disp_n = pend_q;
            end
            ack_n      = load_i || pend_vld_q;
            pend_vld_n = 1'b0;
        end else if (load_i) begin
            pend_n     = data_i;
            pend_vld_n = 1'b1;
        end

        // Outputs for the cycle that the next state describes
        frame_n = is_boundary(state_n, digit_n, cnt_n);
        if (state_n == ST_SHOW) begin
            an_n  = ~(4'b0001 << digit_n);
            bcd_n = eff_code(disp_n, digit_n, lzb_i);
        end
    end

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_START;
            cnt_q      <= '0;
            digit_q    <= 2'd0;
            disp_q     <= 16'hFFFF;
            pend_q     <= 16'hFFFF;
            pend_vld_q <= 1'b0;
            ack_q      <= 1'b0;
            frame_q    <= 1'b0;
            an_q       <= 4'b1111;
            bcd_q      <= CODE_BLANK;
        end else begin
            state_q    <= state_n;
            cnt_q      <= cnt_n;
            digit_q    <= digit_n;
            disp_q     <= disp_n;
            pend_q     <= pend_n;
            pend_vld_q <= pend_vld_n;
            ack_q      <= ack_n;
            frame_q    <= frame_n;
            an_q       <= an_n;
            bcd_q      <= bcd_n;
        end
    end

    assign load_ack_o = ack_q;
    assign frame_o    = frame_q;
    assign an_o       = an_q;
    assign bcd_o      = bcd_q;
    assign digit_o    = digit_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - scoreboard bench for seg_scan_ctrl against a frame-position reference model
module tb_seg_scan_ctrl;

    localparam int DT    = 4;
    localparam int BT    = 2;
    localparam int CW    = 3;
    localparam int SLOT  = DT + BT;
    localparam int FRAME = 4 * SLOT;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        enable_i = 1'b0;
    logic        lzb_i = 1'b0;
    logic        load_i = 1'b0;
    logic [15:0] data_i = 16'h0000;
    logic        load_ack_o;
    logic        frame_o;
    logic [3:0]  bcd_o;
    logic [3:0]  an_o;
    logic [1:0]  digit_o;

    seg_scan_ctrl #(
        .DIGIT_TICKS(DT),
        .BLANK_TICKS(BT),
        .CNT_W(CW)
    ) dut (
        .clk_i(clk),
        .reset_i(reset_i),
        .enable_i(enable_i),
        .lzb_i(lzb_i),
        .load_i(load_i),
        .data_i(data_i),
        .load_ack_o(load_ack_o),
        .frame_o(frame_o),
        .bcd_o(bcd_o),
        .an_o(an_o),
        .digit_o(digit_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [3:0] bcd;
        logic [1:0] digit;
        logic       frame;
        logic       ack;
    } obs_t;

    obs_t  exp_q[$];
    string tag_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    string phase    = "reset";
    bit    cur_lzb  = 1'b0;

    // Reference model: either dark in START, or running at a position 0..FRAME-1
    // measured from the first cycle of digit 0.
    bit          m_start = 1'b1;
    bit          m_first = 1'b1;
    int          m_pos   = 0;
    logic [15:0] m_disp  = 16'hFFFF;
    logic [15:0] m_pend  = 16'hFFFF;
    bit          m_pvld  = 1'b0;
    bit          m_ack   = 1'b0;

    function automatic logic [3:0] ref_code(input logic [15:0] v, input int d, input bit lzb);
        int top;
        top = 0;
        for (int k = 0; k < 4; k++) begin
            if (((v >> (4 * k)) & 16'h000F) != 16'h0000) top = k;
        end
        if (lzb && d > top) return 4'hF;
        return 4'((v >> (4 * d)) & 16'h000F);
    endfunction

    // Apply one cycle of inputs, advance the model, queue the expected outputs.
    task automatic step(input bit rst, input bit en, input bit lzb, input bit ld,
                        input logic [15:0] dat);
        obs_t e;
        bit   bnd;
        int   d;
        int   r;
        reset_i  = rst;
        enable_i = en;
        lzb_i    = lzb;
        load_i   = ld;
        data_i   = dat;
        if (rst) begin
            m_start = 1'b1;
            m_first = 1'b1;
            m_disp  = 16'hFFFF;
            m_pend  = 16'hFFFF;
            m_pvld  = 1'b0;
            m_ack   = 1'b0;
        end else begin
            bnd   = m_start || (m_pos == FRAME - 1);
            m_ack = 1'b0;
            if (bnd) begin
                if (ld) m_disp = dat;
                else if (m_pvld) m_disp = m_pend;
                m_ack  = ld || m_pvld;
                m_pvld = 1'b0;
            end else if (ld) begin
                m_pend = dat;
                m_pvld = 1'b1;
            end
            if (!en) m_start = 1'b1;
            else if (m_start) begin
                m_start = 1'b0;
                m_pos   = 0;
            end else m_pos = (m_pos + 1) % FRAME;
            m_first = 1'b0;
        end
        if (m_start) begin
            e.an    = 4'b1111;
            e.bcd   = 4'hF;
            e.digit = 2'd0;
            e.frame = !m_first;
        end else begin
            d = m_pos / SLOT;
            r = m_pos % SLOT;
            e.digit = 2'(d);
            e.frame = (m_pos == FRAME - 1);
            if (r < DT) begin
                e.an  = ~(4'b0001 << d);
                e.bcd = ref_code(m_disp, d, lzb);
            end else begin
                e.an  = 4'b1111;
                e.bcd = 4'hF;
            end
        end
        e.ack = m_ack;
        exp_q.push_back(e);
        tag_q.push_back(phase);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, cur_lzb, 1'b0, 16'h0000);
    endtask

    task automatic run_to(input int pos);
        int guard;
        guard = 0;
        while ((m_start || m_pos != pos) && guard < 3 * FRAME) begin
            step(1'b0, 1'b1, cur_lzb, 1'b0, 16'h0000);
            guard++;
        end
        n_checks++;
        if (m_start || m_pos != pos) begin
            n_fail++;
            $display("FAIL run_to_%0d: position not reached, got pos %0d start %0b, required pos %0d",
                     pos, m_pos, m_start, pos);
        end
    endtask

    obs_t  mon_e;
    obs_t  mon_a;
    string mon_tag;

    // Monitor: compares every presented output cycle against the queued expectation.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            mon_e   = exp_q.pop_front();
            mon_tag = tag_q.pop_front();
            mon_a.an    = an_o;
            mon_a.bcd   = bcd_o;
            mon_a.digit = digit_o;
            mon_a.frame = frame_o;
            mon_a.ack   = load_ack_o;
            n_checks++;
            if (mon_a !== mon_e) begin
                n_fail++;
                $display("FAIL %s t=%0t: got an=%b bcd=%h digit=%0d frame=%b ack=%b, required an=%b bcd=%h digit=%0d frame=%b ack=%b",
                         mon_tag, $time, mon_a.an, mon_a.bcd, mon_a.digit, mon_a.frame, mon_a.ack,
                         mon_e.an, mon_e.bcd, mon_e.digit, mon_e.frame, mon_e.ack);
            end
        end
    end

    initial begin
        logic [15:0] mask;
        @(negedge clk);
        phase = "reset";
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);

        phase = "scan";
        step(1'b0, 1'b1, 1'b0, 1'b1, 16'h1234);
        idle(2 * FRAME);

        phase = "anti_tear";
        run_to(SLOT + 1);
        step(1'b0, 1'b1, cur_lzb, 1'b1, 16'h5678);
        idle(FRAME + 4);

        phase = "overwrite";
        run_to(3);
        step(1'b0, 1'b1, cur_lzb, 1'b1, 16'h1111);
        run_to(10);
        step(1'b0, 1'b1, cur_lzb, 1'b1, 16'h2222);
        idle(FRAME + 2);

        phase = "lzb_0070";
        cur_lzb = 1'b1;
        step(1'b0, 1'b1, cur_lzb, 1'b1, 16'h0070);
        idle(2 * FRAME);
        phase = "nolzb_0070";
        cur_lzb = 1'b0;
        idle(FRAME);
        phase = "lzb_0000";
        cur_lzb = 1'b1;
        step(1'b0, 1'b1, cur_lzb, 1'b1, 16'h0000);
        idle(2 * FRAME);
        cur_lzb = 1'b0;

        phase = "collision";
        run_to(5);
        step(1'b0, 1'b1, cur_lzb, 1'b1, 16'h9999);
        run_to(FRAME - 1);
        step(1'b0, 1'b1, cur_lzb, 1'b1, 16'hABCD);
        idle(FRAME + 2);

        phase = "disable";
        run_to(2 * SLOT + 1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, cur_lzb, (i == 3), 16'h4321);
        phase = "reenable";
        idle(FRAME + 2);

        phase = "reset_mid";
        run_to(SLOT + 2);
        step(1'b1, 1'b1, cur_lzb, 1'b1, 16'h7777);
        idle(FRAME + 2);
        cur_lzb = 1'b1;
        idle(FRAME);

        phase = "random";
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 31) == 0) cur_lzb = ~cur_lzb;
            case ($urandom_range(0, 3))
                0:       mask = 16'hFFFF;
                1:       mask = 16'h00FF;
                2:       mask = 16'h000F;
                default: mask = 16'h0000;
            endcase
            step($urandom_range(0, 199) == 0, $urandom_range(0, 15) != 0, cur_lzb,
                 $urandom_range(0, 7) == 0, 16'($urandom) & mask);
        end

        @(posedge clk);
        #3;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d expectations left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
